tone_vote_detector: RTL

Parametrised successor to the 4-bin power detector. Takes NUM_BINS signed Goertzel power values per sample and classifies each sample as one dominant bin or silence, using a ratio test plus a noise floor. Runs a WIN_DEPTH sliding-window majority vote over the classifications, then a hit FSM with hold-off that emits one pulse per struck note. Sits between the Goertzel filter bank and the game-logic / Avalon register interface.

---
 rtl/tone_vote_pkg.sv | 20 ++
 rtl/tone_vote_detector_if.sv | 31 +++
 rtl/tone_window_counter.sv | 70 +++++++
 rtl/tone_vote_detector.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/tone_vote_pkg.sv
// Shared types and width helpers for the tone vote detector.
package tone_vote_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    REARM
  } hit_state_e;

  localparam int unsigned SILENCE = 0;

  function automatic int unsigned bin_w(input int unsigned num_bins);
    return $clog2(num_bins + 1);
  endfunction

  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val == 0) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/tone_vote_detector_if.sv
// Sample/result bundle between the Goertzel bank, the detector and game logic.
interface tone_vote_detector_if
  import tone_vote_pkg::*;
#(
  parameter int unsigned NUM_BINS = 4,
  parameter int unsigned PWR_W    = 64
);
  localparam int unsigned BIN_W = bin_w(NUM_BINS);

  logic                      sample_valid;
  logic [NUM_BINS*PWR_W-1:0] power;
  logic [PWR_W-1:0]          noise_floor;
  logic                      flush;
  logic [BIN_W-1:0]          inst_bin;
  logic                      inst_valid;
  logic [BIN_W-1:0]          vote_bin;
  logic                      vote_valid;
  logic                      hit_valid;
  logic [BIN_W-1:0]          hit_bin;

  modport master (
    output sample_valid, power, noise_floor, flush,
    input  inst_bin, inst_valid, vote_bin, vote_valid, hit_valid, hit_bin
  );

  modport slave (
    input  sample_valid, power, noise_floor, flush,
    output inst_bin, inst_valid, vote_bin, vote_valid, hit_valid, hit_bin
  );

endinterface

// File: rtl/tone_window_counter.sv
// Sliding window of class codes with one occupancy counter per code.
module tone_window_counter
  import tone_vote_pkg::*;
#(
  parameter int unsigned NUM_BINS  = 4,
  parameter int unsigned WIN_DEPTH = 16,
  parameter int unsigned BIN_W     = 3,
  parameter int unsigned CNT_W     = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush_i,
  input  logic                      push_i,
  input  logic [BIN_W-1:0]          code_i,
  output logic                      upd_o,
  output logic [NUM_BINS*CNT_W-1:0] counts_o
);

  logic [BIN_W-1:0] win_q [WIN_DEPTH];
  logic [CNT_W-1:0] cnt_q [NUM_BINS+1];
  logic [CNT_W-1:0] cnt_d [NUM_BINS+1];
  logic             upd_q;
  logic [BIN_W-1:0] oldest;

  assign oldest = win_q[WIN_DEPTH-1];

  // Counts always sum to WIN_DEPTH, so the inc/dec pair never wraps.
  always_comb begin
    for (int unsigned c = 0; c <= NUM_BINS; c++) begin
      cnt_d[c] = cnt_q[c];
      if (push_i && (code_i != oldest)) begin
        if (BIN_W'(c) == code_i) begin
          cnt_d[c] = cnt_q[c] + CNT_W'(1);
        end else if (BIN_W'(c) == oldest) begin
          cnt_d[c] = cnt_q[c] - CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      upd_q <= 1'b0;
      for (int unsigned k = 0; k < WIN_DEPTH; k++) begin
        win_q[k] <= BIN_W'(SILENCE);
      end
      for (int unsigned c = 0; c <= NUM_BINS; c++) begin
        cnt_q[c] <= (c == SILENCE) ? CNT_W'(WIN_DEPTH) : '0;
      end
    end else begin
      upd_q <= push_i;
      if (push_i) begin
        win_q[0] <= code_i;
        for (int unsigned k = 1; k < WIN_DEPTH; k++) begin
          win_q[k] <= win_q[k-1];
        end
      end
      for (int unsigned c = 0; c <= NUM_BINS; c++) begin
        cnt_q[c] <= cnt_d[c];
      end
    end
  end

  assign upd_o = upd_q;

  for (genvar g = 0; g < NUM_BINS; g++) begin : g_counts
    assign counts_o[g*CNT_W +: CNT_W] = cnt_q[g+1];
  end

endmodule

// File: rtl/tone_vote_detector.sv
// Per-sample dominant-bin classifier, windowed majority vote and hit FSM with hold-off.
module tone_vote_detector
  import tone_vote_pkg::*;
#(
  parameter int unsigned NUM_BINS    = 4,
  parameter int unsigned PWR_W       = 64,
  parameter int unsigned SHIFT       = 3,
  parameter int unsigned WIN_DEPTH   = 16,
  parameter int unsigned VOTE_THRESH = 8,
  parameter int unsigned HOLDOFF     = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  tone_vote_detector_if.slave  bus
);

  localparam int unsigned BIN_W = bin_w(NUM_BINS);
  localparam int unsigned CNT_W = cnt_w(WIN_DEPTH);
  localparam int unsigned HO_W  = cnt_w(HOLDOFF);

  logic clr;
  assign clr = reset | bus.flush;

  logic signed [PWR_W-1:0] pwr [NUM_BINS];
  logic signed [PWR_W-1:0] nf;
  logic [NUM_BINS-1:0]     dom;
  logic [BIN_W-1:0]        class_d;
  logic [BIN_W-1:0]        inst_bin_q;
  logic                    inst_valid_q;

  assign nf = $signed(bus.noise_floor);

  for (genvar g = 0; g < NUM_BINS; g++) begin : g_unpack
    assign pwr[g] = $signed(bus.power[g*PWR_W +: PWR_W]);
  end

  always_comb begin
    dom = '0;
    for (int unsigned i = 0; i < NUM_BINS; i++) begin
      dom[i] = pwr[i] > nf;
      for (int unsigned j = 0; j < NUM_BINS; j++) begin
        if ((j != i) && !((pwr[i] >>> SHIFT) > pwr[j])) begin
          dom[i] = 1'b0;
        end
      end
    end
  end

  // Scan from the top so the lowest qualifying index is written last.
  always_comb begin
    class_d = BIN_W'(SILENCE);
    for (int unsigned k = 0; k < NUM_BINS; k++) begin
      if (dom[NUM_BINS-1-k]) begin
        class_d = BIN_W'(NUM_BINS - k);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      inst_valid_q <= 1'b0;
      inst_bin_q   <= '0;
    end else begin
      inst_valid_q <= bus.sample_valid;
      if (bus.sample_valid) begin
        inst_bin_q <= class_d;
      end
    end
  end

  logic                      win_upd;
  logic [NUM_BINS*CNT_W-1:0] win_counts;

  tone_window_counter #(
    .NUM_BINS  (NUM_BINS),
    .WIN_DEPTH (WIN_DEPTH),
    .BIN_W     (BIN_W),
    .CNT_W     (CNT_W)
  ) u_win (
    .clk      (clk),
    .rst      (reset),
    .flush_i  (bus.flush),
    .push_i   (inst_valid_q),
    .code_i   (inst_bin_q),
    .upd_o    (win_upd),
    .counts_o (win_counts)
  );

  logic [BIN_W-1:0] vote_d;
  logic [BIN_W-1:0] vote_bin_q;
  logic             vote_valid_q;

  always_comb begin
    vote_d = BIN_W'(SILENCE);
    for (int unsigned k = 0; k < NUM_BINS; k++) begin
      if (win_counts[(NUM_BINS-1-k)*CNT_W +: CNT_W] >= CNT_W'(VOTE_THRESH)) begin
        vote_d = BIN_W'(NUM_BINS - k);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      vote_valid_q <= 1'b0;
      vote_bin_q   <= '0;
    end else begin
      vote_valid_q <= win_upd;
      if (win_upd) begin
        vote_bin_q <= vote_d;
      end
    end
  end

  hit_state_e       state_q, state_d;
  logic [HO_W-1:0]  ho_q, ho_d;
  logic             hit_valid_q, hit_valid_d;
  logic [BIN_W-1:0] hit_bin_q, hit_bin_d;

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= IDLE;
      ho_q        <= '0;
      hit_valid_q <= 1'b0;
      hit_bin_q   <= '0;
    end else begin
      state_q     <= state_d;
      ho_q        <= ho_d;
      hit_valid_q <= hit_valid_d;
      hit_bin_q   <= hit_bin_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ho_d        = ho_q;
    hit_valid_d = 1'b0;
    hit_bin_d   = hit_bin_q;
    if (vote_valid_q) begin
      unique case (state_q)
        IDLE: begin
          if (vote_bin_q != BIN_W'(SILENCE)) begin
            hit_valid_d = 1'b1;
            hit_bin_d   = vote_bin_q;
            ho_d        = HO_W'(HOLDOFF);
            state_d     = (HOLDOFF == 0) ? REARM : HOLD;
          end
        end
        HOLD: begin
          ho_d = ho_q - HO_W'(1);
          if (ho_q == HO_W'(1)) begin
            state_d = REARM;
          end
        end
        REARM: begin
          if (vote_bin_q == BIN_W'(SILENCE)) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.inst_bin   = inst_bin_q;
  assign bus.inst_valid = inst_valid_q;
  assign bus.vote_bin   = vote_bin_q;
  assign bus.vote_valid = vote_valid_q;
  assign bus.hit_valid  = hit_valid_q;
  assign bus.hit_bin    = hit_bin_q;

endmodule
